eager_fork_n: RTL and testbench
===============================

EAGER_FORK_N -- requirements
Module: eager_fork_n

Interface
REQ-001 Parameter SIZE, default 2, number of output channels (SHALL be >= 1).
REQ-002 Parameter DATA_WIDTH, default 32, width of the data payload (SHALL be >= 1).
REQ-003 Ports SHALL be as listed; one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ins  input  DATA_WIDTH  input token data.
REQ-007 ins_valid  input  1  input token valid.
REQ-008 ins_ready  output  1  input token accepted when high with ins_valid.
REQ-009 outs  output  SIZE*DATA_WIDTH  replicated data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 outs_valid  output  SIZE  per-channel valid.
REQ-011 outs_ready  input  SIZE  per-channel ready.
REQ-012 stall_count  output  16  input-stall cycle counter; present only with EAGER_FORK_N_STALL_CNT_EN.

Function
REQ-013 Per channel i, one pending bit pend[i]: 1 = current token not yet delivered on channel i.
REQ-014 outs[i] SHALL equal ins combinationally; zero latency, no data storage.
REQ-015 outs_valid[i] = ins_valid & pend[i].
REQ-016 stop[i] = ins_valid & pend[i] & ~outs_ready[i]; backpressure = OR of stop[i] over all i.
REQ-017 ins_ready = ~backpressure; a channel transfer occurs on channel i when outs_valid[i] & outs_ready[i].
REQ-018 If ins_valid & ins_ready: all pend bits SHALL become 1 next cycle (token fully delivered, next token starts fresh).
REQ-019 If ins_valid & ~ins_ready: pend[i] SHALL become stop[i] (accepted channels clear, refusing channels stay pending).
REQ-020 If ~ins_valid: pend SHALL hold its value.
REQ-021 A channel SHALL receive each token exactly once; a cleared channel SHALL NOT reassert outs_valid until the token completes.
REQ-022 Simultaneous acceptance by all pending channels in one cycle SHALL complete the token in that cycle (ins_ready high, no extra cycle).
REQ-023 No combinational path from outs_ready to outs_valid; outs_ready to ins_ready path is permitted.
REQ-024 SIZE = 1 SHALL behave as a wire: ins_ready = outs_ready[0], outs_valid[0] = ins_valid.

Reset
REQ-025 While rst is high at a rising clk edge, all pend bits SHALL be set to 1.
REQ-026 During/after reset the outputs SHALL be: outs_valid = ins_valid replicated, ins_ready = ~(OR of ins_valid & ~outs_ready[i]), stall_count = 0.
REQ-027 Reset mid-token SHALL discard partial delivery; the held token is re-offered to all channels.

Configuration
REQ-028 Macro EAGER_FORK_N_STALL_CNT_EN defined: stall_count port exists and increments by 1 each cycle with ins_valid & ~ins_ready, saturating at 0xFFFF, cleared by rst.
REQ-029 Macro undefined: stall_count port and counter absent; all other behaviour identical.

Verification (SIZE=3, DATA_WIDTH=8)
REQ-030 After reset, ins=0xA5, ins_valid=1, outs_ready=3'b111 -> outs_valid=3'b111, all outs=0xA5, ins_ready=1 same cycle.
REQ-031 ins_valid=1, outs_ready=3'b101 cycle 1 then 3'b010 cycle 2 -> cycle 1 outs_valid=111, ins_ready=0; cycle 2 outs_valid=010, ins_ready=1; cycle 3 outs_valid=111 for next token.
REQ-032 Channel 0 ready, others not, for 4 cycles -> channel 0 transfers once only; outs_valid=3'b110 cycles 2-4; stall_count=4 (macro on).
REQ-033 rst asserted in cycle 2 of REQ-031 sequence -> pend=111 next cycle, outs_valid=3'b111 re-offer, stall_count=0.
REQ-034 ins_valid=1, outs_ready=000 for 70000 cycles (macro on) -> stall_count saturates at 0xFFFF, no wrap.
REQ-035 ins_valid=0 with random outs_ready -> outs_valid=000, ins_ready=1, pend unchanged.

Source files
------------

// File: rtl/eager_fork_n.sv
// Eager fork: replicates one input token onto SIZE output channels, each channel taking it exactly once.
// Optional input-stall counter on port stall_count, enabled by defining EAGER_FORK_N_STALL_CNT_EN.
module eager_fork_n #(
    parameter int SIZE       = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      ins,
    input  logic                       ins_valid,
    output logic                       ins_ready,
    output logic [SIZE*DATA_WIDTH-1:0] outs,
    output logic [SIZE-1:0]            outs_valid,
    input  logic [SIZE-1:0]            outs_ready
`ifdef EAGER_FORK_N_STALL_CNT_EN
    ,
    output logic [15:0]                stall_count
`endif
);

    logic [SIZE-1:0] pend;
    logic [SIZE-1:0] pend_next;
    logic [SIZE-1:0] stop;

    // Data is a pure fan-out of the input; nothing is stored.
    assign outs = {SIZE{ins}};

    // outs_valid depends only on registered pend and ins_valid, never on outs_ready.
    assign outs_valid = {SIZE{ins_valid}} & pend;
    assign stop       = outs_valid & ~outs_ready;
    assign ins_ready  = ~(|stop);

    always_comb begin
        // NOTE: default first so every path assigns pend_next and no latch is inferred.
        pend_next = pend;
        if (ins_valid) begin
            if (ins_ready)
                pend_next = '1;
            else
                pend_next = stop;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so all registers update together at the edge.
        if (rst)
            pend <= '1;
        else
            pend <= pend_next;
    end

`ifdef EAGER_FORK_N_STALL_CNT_EN
    logic [15:0] stall_cnt;

    // Counts cycles with a token held at the input; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (ins_valid && !ins_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_eager_fork_n.sv
// Self-checking bench for eager_fork_n (SIZE=3, DATA_WIDTH=8): vector table plus corner-case sequences.
module tb_eager_fork_n;

    localparam int SIZE = 3;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [DW-1:0]      ins;
    logic               ins_valid;
    logic               ins_ready;
    logic [SIZE*DW-1:0] outs;
    logic [SIZE-1:0]    outs_valid;
    logic [SIZE-1:0]    outs_ready;
`ifdef EAGER_FORK_N_STALL_CNT_EN
    logic [15:0]        stall_count;
`endif

    int errors = 0;
    int checks = 0;

    eager_fork_n #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
`ifdef EAGER_FORK_N_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   ins;
        logic            vld;
        logic [SIZE-1:0] rdy;
        logic [SIZE-1:0] exp_ov;
        logic            exp_ir;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [DW-1:0] exp);
        for (int ch = 0; ch < SIZE; ch++)
            check($sformatf("%s.outs[%0d]", name, ch), 32'(outs[ch*DW +: DW]), 32'(exp));
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic v, input logic [SIZE-1:0] r);
        ins        = d;
        ins_valid  = v;
        outs_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'h00, 1'b0, 3'b000);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Sequential vectors, pend state carries from one row to the next.
        vecs[0]  = '{8'hA5, 1'b1, 3'b111, 3'b111, 1'b1};
        vecs[1]  = '{8'h3C, 1'b1, 3'b101, 3'b111, 1'b0};
        vecs[2]  = '{8'h3C, 1'b1, 3'b010, 3'b010, 1'b1};
        vecs[3]  = '{8'h5A, 1'b1, 3'b000, 3'b111, 1'b0};
        vecs[4]  = '{8'h5A, 1'b0, 3'b101, 3'b000, 1'b1};
        vecs[5]  = '{8'h5A, 1'b1, 3'b001, 3'b111, 1'b0};
        vecs[6]  = '{8'h5A, 1'b0, 3'b011, 3'b000, 1'b1};
        vecs[7]  = '{8'h5A, 1'b1, 3'b000, 3'b110, 1'b0};
        vecs[8]  = '{8'h5A, 1'b1, 3'b111, 3'b110, 1'b1};
        vecs[9]  = '{8'h77, 1'b1, 3'b100, 3'b111, 1'b0};
        vecs[10] = '{8'h77, 1'b1, 3'b011, 3'b011, 1'b1};

        // Reset-state outputs, with and without a valid token present.
        rst = 1'b1;
        drive(8'h00, 1'b0, 3'b000);
        tick();
        check("rst_idle.outs_valid", 32'(outs_valid), 32'h0);
        check("rst_idle.ins_ready", 32'(ins_ready), 32'h1);
        drive(8'h11, 1'b1, 3'b000);
        tick();
        check("rst_busy.outs_valid", 32'(outs_valid), 32'h7);
        check("rst_busy.ins_ready", 32'(ins_ready), 32'h0);
`ifdef EAGER_FORK_N_STALL_CNT_EN
        check("rst.stall_count", 32'(stall_count), 32'h0);
`endif
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].vld, vecs[i].rdy);
            check($sformatf("vec%0d.outs_valid", i), 32'(outs_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d.ins_ready", i), 32'(ins_ready), 32'(vecs[i].exp_ir));
            check_outs($sformatf("vec%0d", i), vecs[i].ins);
            tick();
        end

        // Channel 0 ready alone for 4 cycles: it takes the token once only.
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(8'hC3, 1'b1, 3'b001);
            check($sformatf("ch0only%0d.outs_valid", c), 32'(outs_valid), (c == 1) ? 32'h7 : 32'h6);
            check($sformatf("ch0only%0d.ins_ready", c), 32'(ins_ready), 32'h0);
            tick();
        end
`ifdef EAGER_FORK_N_STALL_CNT_EN
        check("ch0only.stall_count", 32'(stall_count), 32'd4);
`endif

        // Reset mid-token: partial delivery is discarded and the token re-offered to all.
        do_reset();
        drive(8'h3C, 1'b1, 3'b101);
        check("midrst1.outs_valid", 32'(outs_valid), 32'h7);
        check("midrst1.ins_ready", 32'(ins_ready), 32'h0);
        tick();
        rst = 1'b1;
        drive(8'h3C, 1'b1, 3'b010);
        check("midrst2.outs_valid", 32'(outs_valid), 32'h2);
        tick();
        rst = 1'b0;
        drive(8'h3C, 1'b1, 3'b000);
        check("midrst3.outs_valid", 32'(outs_valid), 32'h7);
        check("midrst3.ins_ready", 32'(ins_ready), 32'h0);
`ifdef EAGER_FORK_N_STALL_CNT_EN
        check("midrst3.stall_count", 32'(stall_count), 32'h0);
`endif
        tick();

        // Idle input: pend holds through random outs_ready.
        do_reset();
        drive(8'h99, 1'b1, 3'b010);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(8'h99, 1'b0, 3'($urandom_range(0, 7)));
            check($sformatf("idle%0d.outs_valid", k), 32'(outs_valid), 32'h0);
            check($sformatf("idle%0d.ins_ready", k), 32'(ins_ready), 32'h1);
            tick();
        end
        drive(8'h99, 1'b1, 3'b000);
        check("idle_hold.outs_valid", 32'(outs_valid), 32'h5);

`ifdef EAGER_FORK_N_STALL_CNT_EN
        // Saturation of the stall counter.
        do_reset();
        drive(8'hEE, 1'b1, 3'b000);
        repeat (65534) @(posedge clk);
        #1;
        check("sat_pre.stall_count", 32'(stall_count), 32'hFFFE);
        repeat (4466) @(posedge clk);
        #1;
        check("sat.stall_count", 32'(stall_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
